// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between an instruction-fetch requester and a data requester.
// Optional MFA watchdog is compiled in by defining MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int FAIR_LIMIT     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_done,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_size,
   output logic        d_gnt,
   output logic        d_done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        MFA,
   output logic [31:0] MAR_OUT,
   output logic [31:0] MDR_OUT,
   output logic        MOP_SEL,
   output logic [1:0]  MOP_SIZE,
   input  logic        MFC,
   input  logic [31:0] MEM_DATA
);
   localparam int         SW        = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
   state_t state, state_next;

   logic [SW-1:0] streak;
   logic          owner_data;
   logic          err_latched;
   logic          streak_full;
   logic          pick_fetch;
   logic          pick_data;
   logic          fetch_bad;
   logic          data_bad;
   logic          active;
   logic          timeout_hit;

   assign streak_full = (streak == SW'(FAIR_LIMIT));
   assign active      = (state == FETCH) || (state == DATA);

   always_comb begin
      pick_fetch = if_req && (!d_req || streak_full);
      pick_data  = d_req && !pick_fetch;
      fetch_bad  = (if_addr[1:0] != 2'b00);
      case (d_size)
         2'd0:    data_bad = 1'b0;
         2'd1:    data_bad = d_addr[0];
         2'd2:    data_bad = (d_addr[1:0] != 2'b00);
         default: data_bad = 1'b1;
      endcase
   end

   // Grants are issued in the IDLE cycle whose closing edge accepts the request;
   // qualifying with rst_n keeps them low while reset is held.
   assign if_gnt = rst_n && (state == IDLE) && pick_fetch;
   assign d_gnt  = rst_n && (state == IDLE) && pick_data;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt;

   assign timeout_hit = active && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (active && !MFC && !timeout_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   // Watchdog compiled out: an access waits for MFC indefinitely.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (pick_fetch) begin
               state_next = fetch_bad ? DONE : FETCH;
            end else if (pick_data) begin
               state_next = data_bad ? DONE : DATA;
            end
         end
         FETCH, DATA: begin
            if (MFC || timeout_hit) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Access registers only load on a grant, so they stay frozen while MFA is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_data  <= 1'b0;
         err_latched <= 1'b0;
         MAR_OUT     <= '0;
         MDR_OUT     <= '0;
         MOP_SEL     <= 1'b0;
         MOP_SIZE    <= '0;
         rdata       <= '0;
      end else if (if_gnt) begin
         owner_data  <= 1'b0;
         err_latched <= fetch_bad;
         MAR_OUT     <= if_addr;
         MDR_OUT     <= '0;
         MOP_SEL     <= 1'b0;
         MOP_SIZE    <= SIZE_WORD;
      end else if (d_gnt) begin
         owner_data  <= 1'b1;
         err_latched <= data_bad;
         MAR_OUT     <= d_addr;
         MDR_OUT     <= d_wdata;
         MOP_SEL     <= d_wr;
         MOP_SIZE    <= d_size;
      end else if (active) begin
         if (MFC) begin
            err_latched <= 1'b0;
            if (!MOP_SEL) begin
               rdata <= MEM_DATA;
            end
         end else if (timeout_hit) begin
            err_latched <= 1'b1;
            rdata       <= '0;
         end
      end
   end

   // Consecutive data grants are only counted while a fetch is actually waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (!if_req || if_gnt) begin
         streak <= '0;
      end else if (d_gnt && !streak_full) begin
         streak <= streak + 1'b1;
      end
   end

   assign MFA     = active;
   assign if_done = (state == DONE) && !owner_data;
   assign d_done  = (state == DONE) && owner_data;
   assign err     = (state == DONE) && err_latched;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: table of single accesses plus
// contention, watchdog and mid-access reset sequences.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_done;
   logic        d_req;
   logic        d_wr;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_size;
   logic        d_gnt;
   logic        d_done;
   logic [31:0] rdata;
   logic        err;
   logic        MFA;
   logic [31:0] MAR_OUT;
   logic [31:0] MDR_OUT;
   logic        MOP_SEL;
   logic [1:0]  MOP_SIZE;
   logic        MFC;
   logic [31:0] MEM_DATA;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT_CYCLES(16), .FAIR_LIMIT(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
      .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata), .err(err),
      .MFA(MFA), .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT), .MOP_SEL(MOP_SEL), .MOP_SIZE(MOP_SIZE),
      .MFC(MFC), .MEM_DATA(MEM_DATA)
   );

   typedef struct {
      logic        is_data;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      int          mfc_at;
      logic [31:0] mem_data;
      logic        drop;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_mfa;
   } vec_t;

   vec_t vecs[12];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v, input int idx);
      int          cyc;
      int          mfa_cnt;
      int          done_cyc;
      logic        stable_ok;
      logic [1:0]  done_pair;
      logic        err_s;
      logic [31:0] rd_s;
      step();
      MFC      = 1'b0;
      MEM_DATA = v.mem_data;
      if (v.is_data) begin
         d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_size = v.size;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      @(negedge clk);
      check($sformatf("t%0d_gnt", idx), {30'd0, if_gnt, d_gnt}, v.is_data ? 32'd1 : 32'd2);
      cyc = 0; mfa_cnt = 0; done_cyc = -1; stable_ok = 1'b1;
      done_pair = 2'b00; err_s = 1'b0; rd_s = '0;
      while (done_cyc < 0 && cyc < 60) begin
         step();
         if (cyc == 0 && v.drop) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (MFA) begin
            mfa_cnt++;
            if ({MAR_OUT, MDR_OUT, MOP_SEL, MOP_SIZE} !==
                {v.addr, v.is_data ? v.wdata : 32'd0, v.is_data & v.wr, v.is_data ? v.size : 2'd2})
               stable_ok = 1'b0;
            MFC = (mfa_cnt == v.mfc_at);
         end else begin
            MFC = 1'b0;
         end
         if (if_done || d_done) begin
            done_cyc = cyc; done_pair = {if_done, d_done}; err_s = err; rd_s = rdata;
         end
      end
      if_req = 1'b0; d_req = 1'b0; MFC = 1'b0;
      check($sformatf("t%0d_done_cycle", idx), done_cyc, v.exp_mfa + 1);
      check($sformatf("t%0d_done_port", idx), {30'd0, done_pair}, v.is_data ? 32'd1 : 32'd2);
      check($sformatf("t%0d_err", idx), 32'(err_s), 32'(v.exp_err));
      check($sformatf("t%0d_rdata", idx), rd_s, v.exp_rdata);
      check($sformatf("t%0d_mfa_cycles", idx), mfa_cnt, v.exp_mfa);
      if (mfa_cnt > 0) check($sformatf("t%0d_latched", idx), 32'(stable_ok), 32'd1);
      $display("txn %0d: %s addr=0x%08h mfa=%0d done@%0d err=%0b rdata=0x%08h",
               idx, v.is_data ? (v.wr ? "DW" : "DR") : "IF", v.addr, mfa_cnt, done_cyc, err_s, rd_s);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int          cyc;
      int          ngr;
      int          mfa_cnt;
      int          done_cyc;
      logic [7:0]  order;
      logic        both;
      logic        err_s;
      logic        saw_done;
      logic [31:0] rd_s;
      vec_t        post;

      //          data  wr    addr          wdata          sz    mfc mem_data       drop  err   exp_rdata      mfa
      vecs[0]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         2'd2, 2, 32'h9C04_4012, 1'b0, 1'b0, 32'h9C04_4012, 2};
      vecs[1]  = '{1'b1, 1'b1, 32'h0000_0080, 32'hA204_4012, 2'd2, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h9C04_4012, 3};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         2'd2, 1, 32'h1122_3344, 1'b0, 1'b0, 32'h1122_3344, 1};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,         2'd2, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h1122_3344, 0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_0103, 32'h0,         2'd0, 1, 32'h0000_00AB, 1'b0, 1'b0, 32'h0000_00AB, 1};
      vecs[5]  = '{1'b1, 1'b1, 32'h0000_0201, 32'h1234,      2'd1, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_00AB, 0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0202, 32'h0,         2'd1, 2, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0000_BEEF, 2};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         2'd3, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_BEEF, 0};
      vecs[8]  = '{1'b0, 1'b0, 32'h0000_0042, 32'h0,         2'd2, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_BEEF, 0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         2'd2, 1, 32'h1357_9BDF, 1'b1, 1'b0, 32'h1357_9BDF, 1};
      vecs[10] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_0055, 2'd0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h1357_9BDF, 1};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         2'd2, 4, 32'h5A5A_A5A5, 1'b0, 1'b0, 32'h5A5A_A5A5, 4};

      // Reset with every request and MFC asserted: all outputs must stay low.
      rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_wr = 1'b1;
      d_addr = 32'h80; d_wdata = 32'hFFFF_FFFF; d_size = 2'd2; MFC = 1'b1; MEM_DATA = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      check("reset_ctl", {23'd0, if_gnt, if_done, d_gnt, d_done, err, MFA, MOP_SEL, MOP_SIZE}, 32'd0);
      check("reset_mar", MAR_OUT, 32'd0);
      check("reset_mdr", MDR_OUT, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      $display("reset: outputs sampled with requests asserted");
      if_req = 1'b0; d_req = 1'b0; MFC = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

      // Contention with immediate MFC: expect D,D,D,F,D,D,D,F (1 = data).
      step();
      if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h80; d_size = 2'd2;
      MFC = 1'b1; MEM_DATA = 32'hC0FF_EE00;
      order = '0; ngr = 0; both = 1'b0; cyc = 0;
      while (ngr < 8 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (if_gnt && d_gnt) both = 1'b1;
         if (if_gnt || d_gnt) begin
            order = {order[6:0], d_gnt};
            ngr++;
         end
         step();
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (3) step();
      MFC = 1'b0;
      check("contend_count", ngr, 32'd8);
      check("contend_order", {24'd0, order}, 32'h0000_00EE);
      check("contend_single_gnt", 32'(both), 32'd0);
      $display("contention: grants=%0d order=%08b", ngr, order);

      // Data read with MFC held low.
      step();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h90; d_size = 2'd2; MFC = 1'b0; MEM_DATA = 32'h0BAD_F00D;
      @(negedge clk);
      check("tmo_gnt", 32'(d_gnt), 32'd1);
      mfa_cnt = 0; done_cyc = -1; cyc = 0; err_s = 1'b0; rd_s = 32'hFFFF_FFFF;
      while (done_cyc < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (MFA) mfa_cnt++;
         if (d_done) begin
            done_cyc = cyc; err_s = err; rd_s = rdata;
         end
      end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      check("tmo_mfa_cycles", mfa_cnt, 32'd16);
      check("tmo_done_cycle", done_cyc, 32'd17);
      check("tmo_err", 32'(err_s), 32'd1);
      check("tmo_rdata", rd_s, 32'd0);
`else
      check("notmo_mfa_cycles", mfa_cnt, 32'd40);
      check("notmo_no_done", done_cyc, 32'hFFFF_FFFF);
      MFC = 1'b1;
      @(negedge clk);
      check("notmo_done", 32'(d_done), 32'd1);
      check("notmo_err", 32'(err), 32'd0);
      check("notmo_rdata", rdata, 32'h0BAD_F00D);
`endif
      $display("stall: mfa=%0d done@%0d", mfa_cnt, done_cyc);
      d_req = 1'b0; MFC = 1'b0;

      // Reset in the middle of a data access.
      step();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h20; d_size = 2'd2; MFC = 1'b0; MEM_DATA = 32'h7654_3210;
      @(negedge clk);
      check("rst_gnt", 32'(d_gnt), 32'd1);
      repeat (2) @(negedge clk);
      check("rst_pre_mfa", 32'(MFA), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rst_mfa_drop", 32'(MFA), 32'd0);
      d_req = 1'b0;
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (d_done) saw_done = 1'b1;
      end
      check("rst_no_done", 32'(saw_done), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      $display("reset mid-access: MFA dropped, done suppressed");
      rst_n = 1'b1;
      post = '{1'b1, 1'b0, 32'h24, 32'h0, 2'd2, 2, 32'h7654_3210, 1'b0, 1'b0, 32'h7654_3210, 2};
      run_txn(post, 99);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
